// File: rtl/pkt_credit_arbiter.sv
// Per-channel saturating packet counts with a round-robin req/start/done
// handshake towards the MAC transmit FSM.
module pkt_credit_arbiter #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned MAX_PKT = 7,
    localparam int unsigned CNT_W  = $clog2(MAX_PKT + 1),
    localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic                    eth_tx_clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       pct_qued,
    input  logic                    tx_start,
    input  logic                    pct_txed,
    input  logic                    err_clr,
    output logic [NUM_CH*CNT_W-1:0] buffer_ready,
    output logic [NUM_CH-1:0]       ch_empty,
    output logic [NUM_CH-1:0]       ch_full,
    output logic                    tx_req,
    output logic [CH_W-1:0]         tx_ch,
    output logic [NUM_CH-1:0]       err_ovf,
    output logic                    err_unf
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT);

    typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CH_W-1:0]   tx_ch_q, tx_ch_d;
    logic [CH_W-1:0]   last_ch_q, last_ch_d;
    logic [NUM_CH-1:0] err_ovf_q, err_ovf_d;
    logic              err_unf_q, err_unf_d;

    logic [NUM_CH-1:0] dec;
    logic [NUM_CH-1:0] ovf_set;
    logic              unf_cnt_set;
    logic              found;
    logic [CH_W-1:0]   pick;
    logic [CH_W-1:0]   idx;

    always_comb begin
        dec         = '0;
        ovf_set     = '0;
        unf_cnt_set = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            dec[i]   = (state_q == BUSY) && pct_txed && (tx_ch_q == CH_W'(i));
            cnt_d[i] = cnt_q[i];
            // A packet arriving while one leaves the same channel nets to zero.
            if (pct_qued[i] && !dec[i]) begin
                if (cnt_q[i] == CNT_MAX) ovf_set[i] = 1'b1;
                else                     cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec[i] && !pct_qued[i]) begin
                if (cnt_q[i] == '0) unf_cnt_set = 1'b1;
                else                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    // Search starts just after the last granted channel and wraps.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = CH_W'((32'(last_ch_q) + k) % NUM_CH);
            if (!found && cnt_q[idx] != '0) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_ch_d   = tx_ch_q;
        last_ch_d = last_ch_q;
        unique case (state_q)
            IDLE: if (found) begin
                state_d   = REQ;
                tx_ch_d   = pick;
                last_ch_d = pick;
            end
            REQ:     if (tx_start) state_d = BUSY;
            BUSY:    if (pct_txed) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_ovf_d = (err_ovf_q & ~{NUM_CH{err_clr}}) | ovf_set;
        err_unf_d = (err_unf_q & ~err_clr) | unf_cnt_set
                  | (pct_txed && (state_q != BUSY));
    end

    always_ff @(posedge eth_tx_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_ch_q   <= '0;
            last_ch_q <= CH_W'(NUM_CH - 1);
            err_ovf_q <= '0;
            err_unf_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            tx_ch_q   <= tx_ch_d;
            last_ch_q <= last_ch_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
            for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        buffer_ready = '0;
        ch_empty     = '0;
        ch_full      = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            buffer_ready[i*CNT_W +: CNT_W] = cnt_q[i];
            ch_empty[i] = (cnt_q[i] == '0);
            ch_full[i]  = (cnt_q[i] == CNT_MAX);
        end
    end

    assign tx_req  = (state_q == REQ);
    assign tx_ch   = tx_ch_q;
    assign err_ovf = err_ovf_q;
    assign err_unf = err_unf_q;

endmodule

// File: tb/tb_pkt_credit_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level
// model of the per-channel packet counts and the round-robin grant.
module tb_pkt_credit_arbiter;

    localparam int NUM_CH  = 4;
    localparam int MAX_PKT = 7;
    localparam int CNT_W   = 3;

    logic                    eth_tx_clk;
    logic                    rst;
    logic [NUM_CH-1:0]       pct_qued;
    logic                    tx_start;
    logic                    pct_txed;
    logic                    err_clr;
    logic [NUM_CH*CNT_W-1:0] buffer_ready;
    logic [NUM_CH-1:0]       ch_empty;
    logic [NUM_CH-1:0]       ch_full;
    logic                    tx_req;
    logic [1:0]              tx_ch;
    logic [NUM_CH-1:0]       err_ovf;
    logic                    err_unf;

    int n_err = 0;
    int n_chk = 0;

    pkt_credit_arbiter #(.NUM_CH(NUM_CH), .MAX_PKT(MAX_PKT)) dut (
        .eth_tx_clk  (eth_tx_clk),
        .rst         (rst),
        .pct_qued    (pct_qued),
        .tx_start    (tx_start),
        .pct_txed    (pct_txed),
        .err_clr     (err_clr),
        .buffer_ready(buffer_ready),
        .ch_empty    (ch_empty),
        .ch_full     (ch_full),
        .tx_req      (tx_req),
        .tx_ch       (tx_ch),
        .err_ovf     (err_ovf),
        .err_unf     (err_unf)
    );

    initial eth_tx_clk = 1'b0;
    always #5 eth_tx_clk = ~eth_tx_clk;

    // Reference: packets waiting per channel, plus whether a grant is
    // offered to the MAC or a packet is on the wire.
    int                m_cnt [NUM_CH];
    int                m_last;
    int                m_ch;
    bit                m_offered;
    bit                m_on_wire;
    bit [NUM_CH-1:0]   m_ovf;
    bit                m_unf;

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
        m_last = NUM_CH - 1;
        m_ch = 0;
        m_offered = 0;
        m_on_wire = 0;
        m_ovf = '0;
        m_unf = 0;
    endfunction

    function automatic void model_step(input logic [NUM_CH-1:0] q, input logic st,
                                       input logic txd, input logic clr);
        int nc [NUM_CH];
        bit [NUM_CH-1:0] oset;
        bit uset;
        oset = '0;
        uset = txd && !m_on_wire;
        for (int i = 0; i < NUM_CH; i++) begin
            bit sent;
            sent  = m_on_wire && txd && (m_ch == i);
            nc[i] = m_cnt[i];
            if (q[i] && !sent) begin
                if (m_cnt[i] >= MAX_PKT) oset[i] = 1;
                else nc[i] = m_cnt[i] + 1;
            end else if (sent && !q[i]) begin
                if (m_cnt[i] == 0) uset = 1;
                else nc[i] = m_cnt[i] - 1;
            end
        end
        if (m_on_wire) begin
            if (txd) m_on_wire = 0;
        end else if (m_offered) begin
            if (st) begin m_offered = 0; m_on_wire = 1; end
        end else begin
            for (int k = 1; k <= NUM_CH; k++) begin
                int c;
                c = (m_last + k) % NUM_CH;
                if (m_cnt[c] > 0) begin
                    m_offered = 1; m_ch = c; m_last = c;
                    break;
                end
            end
        end
        m_cnt = nc;
        m_ovf = (clr ? '0 : m_ovf) | oset;
        m_unf = (clr ? 1'b0 : m_unf) | uset;
    endfunction

    function automatic logic [NUM_CH*CNT_W-1:0] m_br();
        logic [NUM_CH*CNT_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++) r[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] m_empty();
        logic [NUM_CH-1:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i] = (m_cnt[i] == 0);
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] m_full();
        logic [NUM_CH-1:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i] = (m_cnt[i] == MAX_PKT);
        return r;
    endfunction

    // Drives one cycle of inputs, advances the model on the same edge and
    // returns 1 ns after the edge with inputs idle again.
    task automatic tick(input logic [NUM_CH-1:0] q, input logic st,
                        input logic txd, input logic clr);
        pct_qued = q; tx_start = st; pct_txed = txd; err_clr = clr;
        @(posedge eth_tx_clk);
        model_step(q, st, txd, clr);
        #1;
        pct_qued = '0; tx_start = 1'b0; pct_txed = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge eth_tx_clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge eth_tx_clk);
        #1;
        n_chk++; if (ch_empty !== 4'hF) begin n_err++; $display("FAIL por_empty got=%b exp=1111", ch_empty); end
        n_chk++; if (tx_req !== 1'b0) begin n_err++; $display("FAIL por_tx_req got=%b exp=0", tx_req); end
        rst = 1'b0;
        model_reset();
        tick(4'b1011, 0, 0, 0);
        tick(4'b1001, 0, 0, 0);
        tick(4'b0001, 0, 0, 0);
        tick(4'b0000, 1, 0, 0);
        n_chk++; if (buffer_ready !== {3'd2, 3'd0, 3'd1, 3'd3}) begin n_err++; $display("FAIL rst_setup_counts got=%h exp=%h", buffer_ready, {3'd2, 3'd0, 3'd1, 3'd3}); end
        rst = 1'b1;
        #1;
        n_chk++; if (buffer_ready !== '0) begin n_err++; $display("FAIL rst_counts got=%h exp=0", buffer_ready); end
        n_chk++; if (ch_empty !== 4'hF) begin n_err++; $display("FAIL rst_empty got=%b exp=1111", ch_empty); end
        n_chk++; if (ch_full !== 4'h0) begin n_err++; $display("FAIL rst_full got=%b exp=0000", ch_full); end
        n_chk++; if (tx_req !== 1'b0) begin n_err++; $display("FAIL rst_tx_req got=%b exp=0", tx_req); end
        n_chk++; if (tx_ch !== 2'd0) begin n_err++; $display("FAIL rst_tx_ch got=%0d exp=0", tx_ch); end
        n_chk++; if (err_ovf !== 4'h0 || err_unf !== 1'b0) begin n_err++; $display("FAIL rst_errs got=%b/%b exp=0000/0", err_ovf, err_unf); end
        model_reset();
        @(posedge eth_tx_clk);
        #1;
        rst = 1'b0;
        tick(4'b0000, 1, 0, 0);
        n_chk++; if (tx_req !== 1'b0) begin n_err++; $display("FAIL rst_idle_after got=%b exp=0", tx_req); end
        tick(4'b0001, 0, 0, 0);
        tick(4'b0000, 0, 0, 0);
        n_chk++; if (tx_req !== 1'b1 || tx_ch !== 2'd0) begin n_err++; $display("FAIL rst_first_grant got=%b/%0d exp=1/0", tx_req, tx_ch); end
    endtask

    task automatic test_single_packet();
        do_reset();
        tick(4'b0100, 0, 0, 0);
        n_chk++; if (buffer_ready[2*CNT_W +: CNT_W] !== 3'd1 || tx_req !== 1'b0) begin n_err++; $display("FAIL single_cnt got=%0d/%b exp=1/0", buffer_ready[2*CNT_W +: CNT_W], tx_req); end
        tick(4'b0000, 0, 0, 0);
        n_chk++; if (tx_req !== 1'b1 || tx_ch !== 2'd2) begin n_err++; $display("FAIL single_req got=%b/%0d exp=1/2", tx_req, tx_ch); end
        tick(4'b0000, 0, 0, 0);
        tick(4'b0000, 0, 0, 0);
        n_chk++; if (tx_req !== 1'b1 || tx_ch !== 2'd2) begin n_err++; $display("FAIL single_req_hold got=%b/%0d exp=1/2", tx_req, tx_ch); end
        tick(4'b0000, 1, 0, 0);
        n_chk++; if (tx_req !== 1'b0) begin n_err++; $display("FAIL single_busy got=%b exp=0", tx_req); end
        for (int c = 5; c < 9; c++) tick(4'b0000, 0, 0, 0);
        tick(4'b0000, 0, 1, 0);
        n_chk++; if (buffer_ready[2*CNT_W +: CNT_W] !== 3'd0 || ch_empty[2] !== 1'b1) begin n_err++; $display("FAIL single_done got=%0d/%b exp=0/1", buffer_ready[2*CNT_W +: CNT_W], ch_empty[2]); end
        n_chk++; if (err_unf !== 1'b0) begin n_err++; $display("FAIL single_unf got=%b exp=0", err_unf); end
    endtask

    task automatic test_round_robin();
        int exp_order [4] = '{0, 1, 3, 0};
        logic [11:0] exp_br [4] = '{ {3'd1, 3'd0, 3'd1, 3'd1}, {3'd1, 3'd0, 3'd0, 3'd1},
                                     {3'd0, 3'd0, 3'd0, 3'd1}, 12'h000 };
        do_reset();
        tick(4'b1011, 0, 0, 0);
        tick(4'b0001, 0, 0, 0);
        for (int g = 0; g < 4; g++) begin
            int w;
            w = 0;
            while (tx_req !== 1'b1 && w < 10) begin tick('0, 0, 0, 0); w++; end
            n_chk++; if (tx_req !== 1'b1) begin n_err++; $display("FAIL rr_req_timeout grant=%0d got=%b exp=1", g, tx_req); end
            n_chk++; if (int'(tx_ch) !== exp_order[g]) begin n_err++; $display("FAIL rr_order grant=%0d got=%0d exp=%0d", g, tx_ch, exp_order[g]); end
            tick('0, 1, 0, 0);
            tick('0, 0, 1, 0);
            n_chk++; if (buffer_ready !== exp_br[g]) begin n_err++; $display("FAIL rr_counts grant=%0d got=%h exp=%h", g, buffer_ready, exp_br[g]); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int p = 0; p < 8; p++) tick(4'b0010, 0, 0, 0);
        n_chk++; if (buffer_ready[1*CNT_W +: CNT_W] !== 3'd7) begin n_err++; $display("FAIL sat_cnt got=%0d exp=7", buffer_ready[1*CNT_W +: CNT_W]); end
        n_chk++; if (ch_full !== 4'b0010) begin n_err++; $display("FAIL sat_full got=%b exp=0010", ch_full); end
        n_chk++; if (err_ovf !== 4'b0010) begin n_err++; $display("FAIL sat_ovf got=%b exp=0010", err_ovf); end
        tick(4'b0000, 0, 0, 1);
        n_chk++; if (err_ovf !== 4'b0000 || buffer_ready[1*CNT_W +: CNT_W] !== 3'd7) begin n_err++; $display("FAIL sat_clr got=%b/%0d exp=0000/7", err_ovf, buffer_ready[1*CNT_W +: CNT_W]); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        tick(4'b0001, 0, 0, 0);
        tick(4'b0001, 0, 0, 0);
        tick(4'b0001, 0, 0, 0);
        tick(4'b0000, 1, 0, 0);
        tick(4'b0001, 0, 1, 0);
        n_chk++; if (buffer_ready[0 +: CNT_W] !== 3'd3 || tx_req !== 1'b0) begin n_err++; $display("FAIL simul_cnt got=%0d/%b exp=3/0", buffer_ready[0 +: CNT_W], tx_req); end
        n_chk++; if (err_ovf !== 4'h0 || err_unf !== 1'b0) begin n_err++; $display("FAIL simul_errs got=%b/%b exp=0000/0", err_ovf, err_unf); end
        tick(4'b0000, 0, 0, 0);
        n_chk++; if (tx_req !== 1'b1 || tx_ch !== 2'd0) begin n_err++; $display("FAIL simul_regrant_ch0 got=%b/%0d exp=1/0", tx_req, tx_ch); end
        tick(4'b0010, 0, 0, 0);
        tick(4'b0000, 1, 0, 0);
        tick(4'b0001, 0, 1, 0);
        tick(4'b0000, 0, 0, 0);
        n_chk++; if (tx_req !== 1'b1 || tx_ch !== 2'd1) begin n_err++; $display("FAIL simul_regrant_ch1 got=%b/%0d exp=1/1", tx_req, tx_ch); end
    endtask

    task automatic test_abuse();
        do_reset();
        tick(4'b0000, 0, 1, 0);
        n_chk++; if (err_unf !== 1'b1 || buffer_ready !== '0) begin n_err++; $display("FAIL abuse_unf got=%b/%h exp=1/0", err_unf, buffer_ready); end
        tick(4'b0000, 1, 0, 0);
        tick(4'b0000, 0, 0, 0);
        n_chk++; if (tx_req !== 1'b0) begin n_err++; $display("FAIL abuse_start_idle got=%b exp=0", tx_req); end
        tick(4'b0100, 0, 0, 0);
        tick(4'b0000, 0, 0, 0);
        n_chk++; if (tx_req !== 1'b1 || tx_ch !== 2'd2) begin n_err++; $display("FAIL abuse_still_idle got=%b/%0d exp=1/2", tx_req, tx_ch); end
        tick(4'b0000, 0, 0, 1);
        n_chk++; if (err_unf !== 1'b0) begin n_err++; $display("FAIL abuse_clr got=%b exp=0", err_unf); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic [NUM_CH-1:0] q;
            q = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0;
            tick(q, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
            n_chk++; if (buffer_ready !== m_br()) begin n_err++; $display("FAIL rand_counts cyc=%0d got=%h exp=%h", c, buffer_ready, m_br()); end
            n_chk++; if (ch_empty !== m_empty() || ch_full !== m_full()) begin n_err++; $display("FAIL rand_flags cyc=%0d got=%b/%b exp=%b/%b", c, ch_empty, ch_full, m_empty(), m_full()); end
            n_chk++; if (tx_req !== m_offered) begin n_err++; $display("FAIL rand_tx_req cyc=%0d got=%b exp=%b", c, tx_req, m_offered); end
            n_chk++; if (int'(tx_ch) !== m_ch) begin n_err++; $display("FAIL rand_tx_ch cyc=%0d got=%0d exp=%0d", c, tx_ch, m_ch); end
            n_chk++; if (err_ovf !== m_ovf || err_unf !== m_unf) begin n_err++; $display("FAIL rand_errs cyc=%0d got=%b/%b exp=%b/%b", c, err_ovf, err_unf, m_ovf, m_unf); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pct_qued = '0;
        tx_start = 1'b0;
        pct_txed = 1'b0;
        err_clr = 1'b0;
        model_reset();
        test_reset();
        test_single_packet();
        test_round_robin();
        test_saturation();
        test_simultaneous();
        test_abuse();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
